hamming_stream_decoder: RTL and testbench
=========================================

// Module: hamming_stream_decoder
// PURPOSE
// Receive-side SECDED block for the extended Hamming (16,11) link. Accepts a stream of 16-bit
// codewords, corrects single-bit errors and flags double-bit errors. Returns 11-bit data on a
// valid/ready stream. Keeps saturating SEC/DED counters and captures the first uncorrectable word.
// Sits after the channel/memory read port, opposite the hamming_encoder.
// PARAMETERS
// COUNT_W     16  width of each saturating error counter
// CORRECT_EN  1   1: flip the bit in error on SEC; 0: detect only, data passed uncorrected
// PORTS
// clk           in   1        clock, all state on rising edge
// rst_n         in   1        asynchronous active-low reset
// in_valid      in   1        in_code is valid
// in_ready      out  1        block accepts in_code this cycle
// in_code       in   16       codeword: [0]=overall parity, [1],[2],[4],[8]=Hamming parity, rest data
// out_valid     out  1        out_* fields valid
// out_ready     in   1        downstream accepts
// out_data      out  11       data from code bits 3,5,6,7,9..15 (d[0] at bit 3 ... d[10] at bit 15)
// out_sec       out  1        single error seen (corrected if CORRECT_EN)
// out_ded       out  1        double error seen, data unreliable
// out_syndrome  out  4        raw syndrome of this word
// cnt_clr       in   1        sync clear of counters and the error log
// sec_count     out  COUNT_W  saturating count of delivered SEC words
// ded_count     out  COUNT_W  saturating count of delivered DED words
// ded_log_vld   out  1        sticky: a DED word has been delivered since the last clear
// ded_log_code  out  16       raw in_code of the first DED word after the last clear
// BEHAVIOUR
// - Reset: all out_* 0, counters 0, ded_log_vld 0, ded_log_code 0, both pipe stages empty.
// - Syndrome s = XOR of the indices i (1..15) where code[i]=1. Overall parity p = ^code[15:0].
// - Classification:
//   s=0,p=0 -> clean.
//   p=1 -> SEC; bit s is in error (s=0 means parity bit 0). Data is unaffected when s is a parity position.
//   s!=0,p=0 -> DED; no correction.
// - Two-stage pipeline.
//   S1 registers in_code, s and p.
//   S2 (the output register) registers corrected data, flags and syndrome.
// - Latency: an input accepted in cycle N gives out_valid in cycle N+2 when there is no backpressure.
// - Handshake:
//   s2_adv = !out_valid | out_ready.
//   s1_adv = !s1_valid | s2_adv.
//   in_ready = s1_adv (combinational, with no dependency on in_valid).
// - Throughput: 1 word/cycle while out_ready=1. No word is lost or duplicated under any stall pattern.
// - Output stability: out_* hold stable while out_valid=1 and out_ready=0.
// - Counters and log update only on output handshake (out_valid & out_ready), so each word is counted once.
// - Counters saturate at all-ones and never wrap.
// - ded_log_code loads only when ded_log_vld=0. Later DED words leave it unchanged.
// - cnt_clr coinciding with an output handshake: clear wins. That word's counter/log update is dropped.
// - cnt_clr has no effect on the pipeline or the handshake.
// - Async reset mid-stream flushes both stages immediately. The first accept after release is in_ready=1 at the next edge.
// TESTING
// - d=11'h18E encoded, no error -> 2 cycles later out_data=11'h18E, sec=0, ded=0, syndrome=0.
// - Same codeword with bit 2 flipped -> out_data=11'h18E, sec=1, ded=0, syndrome=4'd2, sec_count=1.
// - Bits 2 and 3 flipped -> ded=1, sec=0, syndrome=4'd1, ded_log_vld=1, ded_log_code=flipped word.
//   A second DED word leaves ded_log_code unchanged.
// - Bit 0 flipped -> sec=1, syndrome=0, data intact. Bit 9 flipped with CORRECT_EN=0 -> sec=1, data wrong.
// - Stream of 8 words with random out_ready -> all 8 delivered in order.
//   out_* stable during every stall; max rate 1 word/cycle when out_ready=1.
// - COUNT_W=2: 5 SEC words -> sec_count stays 3. cnt_clr on the handshake of a DED word
//   -> ded_count=0, ded_log_vld=0.

Source files
------------

// File: rtl/hamming_stream_decoder.sv
// hamming_stream_decoder: receive-side SECDED for the extended Hamming (16,11) link.
// Two-stage valid/ready pipeline (syndrome stage, output register) with saturating
// SEC/DED counters and a capture of the first uncorrectable codeword.
module hamming_stream_decoder #(
  parameter int unsigned COUNT_W    = 16,
  parameter bit          CORRECT_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  // codeword input stream
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        in_code,
  // decoded output stream
  output logic               out_valid,
  input  logic               out_ready,
  output logic [10:0]        out_data,
  output logic               out_sec,
  output logic               out_ded,
  output logic [3:0]         out_syndrome,
  // error statistics
  input  logic               cnt_clr,
  output logic [COUNT_W-1:0] sec_count,
  output logic [COUNT_W-1:0] ded_count,
  output logic               ded_log_vld,
  output logic [15:0]        ded_log_code
);

  localparam int unsigned CODE_W = 16;
  localparam int unsigned DATA_W = 11;
  localparam int unsigned SYN_W  = 4;

  // stage 1 registers
  logic              s1_valid_q, s1_valid_d;
  logic [CODE_W-1:0] s1_code_q,  s1_code_d;
  logic [SYN_W-1:0]  s1_syn_q,   s1_syn_d;
  logic              s1_par_q,   s1_par_d;

  // stage 2 (output) registers
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              out_sec_q,   out_sec_d;
  logic              out_ded_q,   out_ded_d;
  logic [SYN_W-1:0]  out_syn_q,   out_syn_d;
  logic [CODE_W-1:0] out_code_q,  out_code_d;

  // statistics registers
  logic [COUNT_W-1:0] sec_count_q, sec_count_d;
  logic [COUNT_W-1:0] ded_count_q, ded_count_d;
  logic               log_vld_q,   log_vld_d;
  logic [CODE_W-1:0]  log_code_q,  log_code_d;

  // combinational helpers
  logic              s1_adv;
  logic              s2_adv;
  logic              out_hs;
  logic [SYN_W-1:0]  in_syn;
  logic              in_par;
  logic [DATA_W-1:0] data_flip;
  logic [DATA_W-1:0] s1_data;

  // Handshake: a stage advances when its downstream slot is free or draining.
  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  assign out_hs   = out_valid_q && out_ready;

  // Syndrome is the XOR of the indices of set bits; bit 0 carries overall parity only.
  always_comb begin
    in_syn = '0;
    for (int unsigned i = 1; i < CODE_W; i++) begin
      if (in_code[i]) begin
        in_syn = in_syn ^ SYN_W'(i);
      end
    end
    in_par = ^in_code;
  end

  // Stage 1 next state: capture codeword, syndrome and parity on advance.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_code_d  = s1_code_q;
    s1_syn_d   = s1_syn_q;
    s1_par_d   = s1_par_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_code_d = in_code;
        s1_syn_d  = in_syn;
        s1_par_d  = in_par;
      end
    end
  end

  // Map the erroneous code position onto the data field; parity positions leave data alone.
  always_comb begin
    data_flip = '0;
    case (s1_syn_q)
      4'd3:    data_flip = DATA_W'(1);
      4'd5:    data_flip = DATA_W'(2);
      4'd6:    data_flip = DATA_W'(4);
      4'd7:    data_flip = DATA_W'(8);
      4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15:
               data_flip = DATA_W'(1) << (s1_syn_q - SYN_W'(5));
      default: data_flip = '0;
    endcase
    if (!(CORRECT_EN && s1_par_q)) begin
      data_flip = '0;
    end
    s1_data = {s1_code_q[15:9], s1_code_q[7:5], s1_code_q[3]} ^ data_flip;
  end

  // Stage 2 next state: load classified word when the output slot can advance.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sec_d   = out_sec_q;
    out_ded_d   = out_ded_q;
    out_syn_d   = out_syn_q;
    out_code_d  = out_code_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = s1_data;
        out_sec_d  = s1_par_q;
        out_ded_d  = !s1_par_q && (s1_syn_q != '0);
        out_syn_d  = s1_syn_q;
        out_code_d = s1_code_q;
      end
    end
  end

  // Statistics next state: update on delivery only; a simultaneous clear wins.
  always_comb begin
    sec_count_d = sec_count_q;
    ded_count_d = ded_count_q;
    log_vld_d   = log_vld_q;
    log_code_d  = log_code_q;
    if (cnt_clr) begin
      sec_count_d = '0;
      ded_count_d = '0;
      log_vld_d   = 1'b0;
      log_code_d  = '0;
    end else if (out_hs) begin
      if (out_sec_q && (sec_count_q != '1)) begin
        sec_count_d = sec_count_q + COUNT_W'(1);
      end
      if (out_ded_q && (ded_count_q != '1)) begin
        ded_count_d = ded_count_q + COUNT_W'(1);
      end
      if (out_ded_q && !log_vld_q) begin
        log_vld_d  = 1'b1;
        log_code_d = out_code_q;
      end
    end
  end

  // Pipeline state registers; async reset empties both stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_code_q   <= '0;
      s1_syn_q    <= '0;
      s1_par_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sec_q   <= 1'b0;
      out_ded_q   <= 1'b0;
      out_syn_q   <= '0;
      out_code_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_code_q   <= s1_code_d;
      s1_syn_q    <= s1_syn_d;
      s1_par_q    <= s1_par_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sec_q   <= out_sec_d;
      out_ded_q   <= out_ded_d;
      out_syn_q   <= out_syn_d;
      out_code_q  <= out_code_d;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_count_q <= '0;
      ded_count_q <= '0;
      log_vld_q   <= 1'b0;
      log_code_q  <= '0;
    end else begin
      sec_count_q <= sec_count_d;
      ded_count_q <= ded_count_d;
      log_vld_q   <= log_vld_d;
      log_code_q  <= log_code_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_sec      = out_sec_q;
  assign out_ded      = out_ded_q;
  assign out_syndrome = out_syn_q;
  assign sec_count    = sec_count_q;
  assign ded_count    = ded_count_q;
  assign ded_log_vld  = log_vld_q;
  assign ded_log_code = log_code_q;

endmodule

// File: tb/tb_hamming_stream_decoder.sv
// Directed bench for hamming_stream_decoder: instance a (defaults) and
// instance b (COUNT_W=2, CORRECT_EN=0).
module tb_hamming_stream_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_sec, a_out_ded;
  logic        a_cnt_clr, a_ded_log_vld;
  logic [15:0] a_in_code, a_sec_count, a_ded_count, a_ded_log_code;
  logic [10:0] a_out_data;
  logic [3:0]  a_out_syndrome;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_sec, b_out_ded;
  logic        b_cnt_clr, b_ded_log_vld;
  logic [15:0] b_in_code, b_ded_log_code;
  logic [1:0]  b_sec_count, b_ded_count;
  logic [10:0] b_out_data;
  logic [3:0]  b_out_syndrome;

  int n_checks = 0;
  int n_fail   = 0;

  hamming_stream_decoder u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_code(a_in_code),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_sec(a_out_sec), .out_ded(a_out_ded), .out_syndrome(a_out_syndrome),
    .cnt_clr(a_cnt_clr), .sec_count(a_sec_count), .ded_count(a_ded_count),
    .ded_log_vld(a_ded_log_vld), .ded_log_code(a_ded_log_code)
  );

  hamming_stream_decoder #(.COUNT_W(2), .CORRECT_EN(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_code(b_in_code),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_sec(b_out_sec), .out_ded(b_out_ded), .out_syndrome(b_out_syndrome),
    .cnt_clr(b_cnt_clr), .sec_count(b_sec_count), .ded_count(b_ded_count),
    .ded_log_vld(b_ded_log_vld), .ded_log_code(b_ded_log_code)
  );

  // Reference encoder: data into positions 3,5,6,7,9..15, Hamming parity, then overall parity.
  function automatic logic [15:0] enc(input logic [10:0] d);
    logic [15:0] c;
    logic [3:0]  s;
    c = '0;
    c[3] = d[0];
    c[7:5] = d[3:1];
    c[15:9] = d[10:4];
    s = '0;
    for (int i = 1; i < 16; i++) if (c[i]) s = s ^ 4'(i);
    c[1] = s[0]; c[2] = s[1]; c[4] = s[2]; c[8] = s[3];
    c[0] = ^c;
    return c;
  endfunction

  // One word through an idle pipe; returns at the falling edge of its output cycle.
  task automatic run_word(input bit sel, input logic [15:0] code);
    @(posedge clk); #1;
    if (sel) begin b_in_valid = 1'b1; b_in_code = code; end
    else     begin a_in_valid = 1'b1; a_in_code = code; end
    @(posedge clk); #1;
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_in_valid = 0; a_in_code = '0; a_out_ready = 1; a_cnt_clr = 0;
    b_in_valid = 0; b_in_code = '0; b_out_ready = 1; b_cnt_clr = 0;
    repeat (3) @(negedge clk);
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b exp 0", a_out_valid); end
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b exp 1", a_in_ready); end
    n_checks++; if (a_out_data !== 11'h0) begin n_fail++; $display("FAIL reset out_data: got %h exp 0", a_out_data); end
    n_checks++; if ({a_out_sec, a_out_ded, a_out_syndrome} !== 6'h0) begin n_fail++; $display("FAIL reset flags: got %b%b %h exp 0", a_out_sec, a_out_ded, a_out_syndrome); end
    n_checks++; if ({a_sec_count, a_ded_count} !== 32'h0) begin n_fail++; $display("FAIL reset counters: got %h %h exp 0", a_sec_count, a_ded_count); end
    n_checks++; if ({a_ded_log_vld, a_ded_log_code} !== 17'h0) begin n_fail++; $display("FAIL reset log: got %b %h exp 0", a_ded_log_vld, a_ded_log_code); end
    n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset b out_valid: got %b exp 0", b_out_valid); end
    rst_n = 1'b1;
  endtask

  task automatic test_clean();
    @(posedge clk); #1; a_in_valid = 1'b1; a_in_code = 16'h30F3;
    @(negedge clk);
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL clean in_ready: got %b exp 1", a_in_ready); end
    @(posedge clk); #1; a_in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL clean latency N+1 out_valid: got %b exp 0", a_out_valid); end
    @(negedge clk);
    n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL clean latency N+2 out_valid: got %b exp 1", a_out_valid); end
    n_checks++; if (a_out_data !== 11'h18E) begin n_fail++; $display("FAIL clean data: got %h exp 18e", a_out_data); end
    n_checks++; if ({a_out_sec, a_out_ded, a_out_syndrome} !== 6'h0) begin n_fail++; $display("FAIL clean flags: got %b%b %h exp 0 0 0", a_out_sec, a_out_ded, a_out_syndrome); end
    @(posedge clk); @(negedge clk);
    n_checks++; if ({a_sec_count, a_ded_count} !== 32'h0) begin n_fail++; $display("FAIL clean counters: got %h %h exp 0 0", a_sec_count, a_ded_count); end
  endtask

  task automatic test_sec();
    run_word(1'b0, 16'h30F7);
    n_checks++; if (a_out_data !== 11'h18E) begin n_fail++; $display("FAIL sec data: got %h exp 18e", a_out_data); end
    n_checks++; if ({a_out_sec, a_out_ded} !== 2'b10) begin n_fail++; $display("FAIL sec flags: got %b%b exp 10", a_out_sec, a_out_ded); end
    n_checks++; if (a_out_syndrome !== 4'd2) begin n_fail++; $display("FAIL sec syndrome: got %0d exp 2", a_out_syndrome); end
    @(posedge clk); @(negedge clk);
    n_checks++; if (a_sec_count !== 16'd1) begin n_fail++; $display("FAIL sec count: got %0d exp 1", a_sec_count); end
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL sec no duplicate: got %b exp 0", a_out_valid); end
  endtask

  task automatic test_ded();
    run_word(1'b0, 16'h30FF);
    n_checks++; if ({a_out_sec, a_out_ded} !== 2'b01) begin n_fail++; $display("FAIL ded flags: got %b%b exp 01", a_out_sec, a_out_ded); end
    n_checks++; if (a_out_syndrome !== 4'd1) begin n_fail++; $display("FAIL ded syndrome: got %0d exp 1", a_out_syndrome); end
    @(posedge clk); @(negedge clk);
    n_checks++; if (a_ded_log_vld !== 1'b1) begin n_fail++; $display("FAIL ded log_vld: got %b exp 1", a_ded_log_vld); end
    n_checks++; if (a_ded_log_code !== 16'h30FF) begin n_fail++; $display("FAIL ded log_code: got %h exp 30ff", a_ded_log_code); end
    n_checks++; if ({a_ded_count, a_sec_count} !== {16'd1, 16'd1}) begin n_fail++; $display("FAIL ded counters: got ded %0d sec %0d exp 1 1", a_ded_count, a_sec_count); end
    run_word(1'b0, 16'h3093);
    n_checks++; if ({a_out_ded, a_out_syndrome} !== {1'b1, 4'd3}) begin n_fail++; $display("FAIL ded2 flags: got %b %0d exp 1 3", a_out_ded, a_out_syndrome); end
    @(posedge clk); @(negedge clk);
    n_checks++; if (a_ded_log_code !== 16'h30FF) begin n_fail++; $display("FAIL ded2 log_code held: got %h exp 30ff", a_ded_log_code); end
    n_checks++; if (a_ded_count !== 16'd2) begin n_fail++; $display("FAIL ded2 count: got %0d exp 2", a_ded_count); end
  endtask

  task automatic test_parity_bits();
    run_word(1'b0, 16'h30F2);
    n_checks++; if ({a_out_sec, a_out_ded, a_out_syndrome} !== {2'b10, 4'd0}) begin n_fail++; $display("FAIL bit0 flags: got %b%b %0d exp 10 0", a_out_sec, a_out_ded, a_out_syndrome); end
    n_checks++; if (a_out_data !== 11'h18E) begin n_fail++; $display("FAIL bit0 data: got %h exp 18e", a_out_data); end
    @(posedge clk); @(negedge clk);
    n_checks++; if (a_sec_count !== 16'd2) begin n_fail++; $display("FAIL bit0 count: got %0d exp 2", a_sec_count); end
    run_word(1'b0, 16'h32F3);
    n_checks++; if (a_out_data !== 11'h18E) begin n_fail++; $display("FAIL bit9 corrected data: got %h exp 18e", a_out_data); end
    n_checks++; if ({a_out_sec, a_out_syndrome} !== {1'b1, 4'd9}) begin n_fail++; $display("FAIL bit9 flags: got %b %0d exp 1 9", a_out_sec, a_out_syndrome); end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_detect_only_saturate();
    logic [1:0] exp_cnt;
    run_word(1'b1, 16'h32F3);
    n_checks++; if (b_out_data !== 11'h19E) begin n_fail++; $display("FAIL detect-only data: got %h exp 19e", b_out_data); end
    n_checks++; if ({b_out_sec, b_out_ded, b_out_syndrome} !== {2'b10, 4'd9}) begin n_fail++; $display("FAIL detect-only flags: got %b%b %0d exp 10 9", b_out_sec, b_out_ded, b_out_syndrome); end
    @(posedge clk); @(negedge clk);
    n_checks++; if (b_sec_count !== 2'd1) begin n_fail++; $display("FAIL detect-only count: got %0d exp 1", b_sec_count); end
    for (int k = 0; k < 4; k++) begin
      exp_cnt = (k == 0) ? 2'd2 : 2'd3;
      run_word(1'b1, 16'h30F7);
      n_checks++; if (b_out_data !== 11'h18E) begin n_fail++; $display("FAIL saturate data %0d: got %h exp 18e", k, b_out_data); end
      @(posedge clk); @(negedge clk);
      n_checks++; if (b_sec_count !== exp_cnt) begin n_fail++; $display("FAIL saturate count %0d: got %0d exp %0d", k, b_sec_count, exp_cnt); end
    end
  endtask

  task automatic test_clr_on_handshake();
    run_word(1'b1, 16'h3093);
    @(posedge clk); @(negedge clk);
    n_checks++; if ({b_ded_count, b_ded_log_vld, b_ded_log_code} !== {2'd1, 1'b1, 16'h3093}) begin n_fail++; $display("FAIL pre-clr state: got %0d %b %h exp 1 1 3093", b_ded_count, b_ded_log_vld, b_ded_log_code); end
    run_word(1'b1, 16'h30FF);
    n_checks++; if ({b_out_valid, b_out_ded} !== 2'b11) begin n_fail++; $display("FAIL clr word present: got %b%b exp 11", b_out_valid, b_out_ded); end
    b_cnt_clr = 1'b1;
    @(posedge clk); #1; b_cnt_clr = 1'b0;
    @(negedge clk);
    n_checks++; if ({b_ded_count, b_sec_count} !== 4'h0) begin n_fail++; $display("FAIL clr counters: got ded %0d sec %0d exp 0 0", b_ded_count, b_sec_count); end
    n_checks++; if ({b_ded_log_vld, b_ded_log_code} !== 17'h0) begin n_fail++; $display("FAIL clr log: got %b %h exp 0 0", b_ded_log_vld, b_ded_log_code); end
    n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL clr pipeline drained: got %b exp 0", b_out_valid); end
  endtask

  task automatic test_stream_backpressure();
    logic [10:0] dv [8];
    int          eb [8];
    logic [15:0] w  [8];
    logic [10:0] h_data;
    logic [3:0]  h_syn;
    logic        h_sec, h_ded, stalled;
    int tx, rx;
    dv = '{11'h001, 11'h7FF, 11'h2AA, 11'h555, 11'h123, 11'h400, 11'h0F0, 11'h18E};
    eb = '{-1, 3, -1, 15, 8, -1, 0, 12};
    for (int i = 0; i < 8; i++) w[i] = enc(dv[i]) ^ ((eb[i] >= 0) ? (16'(1) << eb[i]) : 16'h0);
    tx = 0; rx = 0; stalled = 1'b0;
    h_data = '0; h_syn = '0; h_sec = 1'b0; h_ded = 1'b0;
    for (int cyc = 0; cyc < 300 && rx < 8; cyc++) begin
      @(posedge clk); #1;
      a_out_ready = (cyc % 3 == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      a_in_valid  = (tx < 8);
      if (tx < 8) a_in_code = w[tx];
      @(negedge clk);
      if (stalled) begin
        n_checks++; if ({a_out_valid, a_out_data, a_out_sec, a_out_ded, a_out_syndrome} !== {1'b1, h_data, h_sec, h_ded, h_syn}) begin n_fail++; $display("FAIL stall stability cyc %0d: got %b %h %b%b %h exp 1 %h %b%b %h", cyc, a_out_valid, a_out_data, a_out_sec, a_out_ded, a_out_syndrome, h_data, h_sec, h_ded, h_syn); end
      end
      if (a_out_valid && a_out_ready) begin
        n_checks++; if ({a_out_data, a_out_sec} !== {dv[rx], 1'(eb[rx] >= 0)}) begin n_fail++; $display("FAIL stream word %0d: got %h sec %b exp %h sec %b", rx, a_out_data, a_out_sec, dv[rx], eb[rx] >= 0); end
        rx++;
      end
      stalled = a_out_valid && !a_out_ready;
      h_data = a_out_data; h_sec = a_out_sec; h_ded = a_out_ded; h_syn = a_out_syndrome;
      if (a_in_valid && a_in_ready) tx++;
    end
    @(posedge clk); #1; a_in_valid = 1'b0; a_out_ready = 1'b1;
    n_checks++; if (rx !== 8) begin n_fail++; $display("FAIL stream delivered count: got %0d exp 8", rx); end
    repeat (2) @(negedge clk);
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL stream extra word: got out_valid %b exp 0", a_out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] dv [6];
    int rx, first, last;
    for (int i = 0; i < 6; i++) dv[i] = 11'(i * 165 + 1);
    rx = 0; first = -1; last = -1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(posedge clk); #1;
      a_out_ready = 1'b1;
      a_in_valid  = (cyc < 6);
      if (cyc < 6) a_in_code = enc(dv[cyc]);
      @(negedge clk);
      if (a_in_valid) begin
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b in_ready cyc %0d: got %b exp 1", cyc, a_in_ready); end
      end
      if (a_out_valid) begin
        if (first < 0) first = cyc;
        last = cyc;
        if (rx < 6) begin
          n_checks++; if (a_out_data !== dv[rx]) begin n_fail++; $display("FAIL b2b word %0d: got %h exp %h", rx, a_out_data, dv[rx]); end
        end
        rx++;
      end
    end
    @(posedge clk); #1; a_in_valid = 1'b0;
    n_checks++; if ({rx, first, last} !== {32'sd6, 32'sd2, 32'sd7}) begin n_fail++; $display("FAIL b2b timing: got n=%0d first=%0d last=%0d exp 6 2 7", rx, first, last); end
  endtask

  task automatic test_reset_mid_stream();
    @(posedge clk); #1; a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_code = enc(11'h055);
    @(posedge clk); #1; a_in_code = enc(11'h066);
    @(posedge clk); #1; a_in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if ({a_out_valid, a_in_ready} !== 2'b10) begin n_fail++; $display("FAIL mid full pipe: got valid %b ready %b exp 1 0", a_out_valid, a_in_ready); end
    rst_n = 1'b0;
    #1;
    n_checks++; if ({a_out_valid, a_in_ready} !== 2'b01) begin n_fail++; $display("FAIL mid async flush: got valid %b ready %b exp 0 1", a_out_valid, a_in_ready); end
    n_checks++; if ({a_sec_count, a_ded_log_vld} !== 17'h0) begin n_fail++; $display("FAIL mid reset stats: got %0d %b exp 0 0", a_sec_count, a_ded_log_vld); end
    #2; rst_n = 1'b1;
    a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_code = enc(11'h0AB);
    #1;
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL mid release in_ready: got %b exp 1", a_in_ready); end
    @(posedge clk); #1; a_in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL mid ghost word: got %b exp 0", a_out_valid); end
    @(negedge clk);
    n_checks++; if ({a_out_valid, a_out_data} !== {1'b1, 11'h0AB}) begin n_fail++; $display("FAIL mid first word: got %b %h exp 1 0ab", a_out_valid, a_out_data); end
    @(negedge clk);
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL mid flushed word reappeared: got %b exp 0", a_out_valid); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_sec();
    test_ded();
    test_parity_bits();
    test_detect_only_saturate();
    test_clr_on_handshake();
    test_stream_backpressure();
    test_back_to_back();
    test_reset_mid_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
